// File: rtl/ifu_pkg.sv
// Shared definitions for the instruction fetch unit.
//   INSTR_W       width of an instruction word and of a PC
//   OPC_*         supported opcode classes (instr[6:2])
//   ifu_state_e   fetch FSM state encoding
//   is_illegal()  opcode screen used when IFU_ILLEGAL_CHECK_EN is defined
package ifu_pkg;

  localparam int INSTR_W = 32;

  localparam logic [4:0] OPC_RTYPE  = 5'b01100;
  localparam logic [4:0] OPC_LOAD   = 5'b00000;
  localparam logic [4:0] OPC_STORE  = 5'b01000;
  localparam logic [4:0] OPC_BRANCH = 5'b11000;
  localparam logic [4:0] OPC_IMM    = 5'b00100;

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    WAIT  = 2'd1,
    DROP  = 2'd2
  } ifu_state_e;

  // A word is illegal if it is not a 32-bit encoding or its opcode class is unsupported.
  function automatic logic is_illegal(input logic [INSTR_W-1:0] w);
    logic opc_ok;
    opc_ok = (w[6:2] == OPC_RTYPE) || (w[6:2] == OPC_LOAD) || (w[6:2] == OPC_STORE) ||
             (w[6:2] == OPC_BRANCH) || (w[6:2] == OPC_IMM);
    return (w[1:0] != 2'b11) || !opc_ok;
  endfunction

endpackage

// File: rtl/ifu_queue.sv
// Synchronous prefetch FIFO for the fetch unit.
// Ports:
//   clk, rst   clock, synchronous active-high reset
//   push       write wdata at the tail
//   pop        drop the head (caller guarantees count != 0)
//   flush      empty the queue; wins over push/pop
//   wdata      entry payload
//   rdata      head payload, read straight from storage registers
//   count      number of valid entries (0..DEPTH)
// DEPTH must be a power of 2 so the pointers wrap naturally.
module ifu_queue #(
  parameter int DEPTH = 2,
  parameter int WIDTH = 64
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  input  logic [WIDTH-1:0]         wdata,
  output logic [WIDTH-1:0]         rdata,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [AW-1:0]    wr_ptr_q;
  logic [AW-1:0]    rd_ptr_q;
  logic [CW-1:0]    count_q;

  always_ff @(posedge clk) begin
    if (rst || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      unique case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: count gates every use of it.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wr_ptr_q] <= wdata;
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: issues sequential word fetches to imem (at most one
// outstanding), buffers responses with their PC in a small prefetch queue and
// presents the head to decode on a valid/ready handshake. A redirect flushes
// the queue and restarts fetch at the new PC.
// Ports:
//   clk, rst                 clock, synchronous active-high reset
//   imem_req/addr/ready      fetch request channel (req & ready = issued)
//   imem_rvalid/rdata        in-order response channel
//   instr_valid/instr/pc     queue head towards decode
//   instr_illegal            head opcode unsupported
//   instr_ready              decode pops the head
//   redirect_valid/pc        flush and restart fetch
// Build option: define IFU_ILLEGAL_CHECK_EN to compute instr_illegal per entry;
// otherwise it is tied low and no flag is stored.
//
// state | meaning
// FETCH | no request outstanding
// WAIT  | one request outstanding, response will be queued
// DROP  | one request outstanding, response will be discarded
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = 32'h0000_0000,
  parameter int          FIFO_DEPTH = 2
) (
  input  logic               clk,
  input  logic               rst,
  output logic               imem_req,
  output logic [31:0]        imem_addr,
  input  logic               imem_ready,
  input  logic               imem_rvalid,
  input  logic [INSTR_W-1:0] imem_rdata,
  output logic               instr_valid,
  output logic [INSTR_W-1:0] instr,
  output logic [31:0]        instr_pc,
  output logic               instr_illegal,
  input  logic               instr_ready,
  input  logic               redirect_valid,
  input  logic [31:0]        redirect_pc
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;
`ifdef IFU_ILLEGAL_CHECK_EN
  localparam int PW = 1 + 32 + INSTR_W;
`else
  localparam int PW = 32 + INSTR_W;
`endif

  ifu_state_e   state_q;
  logic [31:0]  fetch_pc_q, fetch_pc_d;
  logic [31:0]  req_pc_q;

  logic [CW-1:0] count;
  logic [CW-1:0] occ;
  logic          pop, push, room, issue;
  logic [PW-1:0] q_wdata, q_rdata;
  logic          unused_rpc_lsbs;

  assign unused_rpc_lsbs = ^redirect_pc[1:0];

  // The outstanding request reserves a slot so its response can always be queued.
  assign occ  = count + CW'(state_q != FETCH);
  assign pop  = instr_valid && instr_ready && !redirect_valid;
  assign room = (occ - CW'(pop)) < CW'(FIFO_DEPTH);
  assign push = (state_q == WAIT) && imem_rvalid && !redirect_valid;

  assign imem_req   = !rst && !redirect_valid && room &&
                      ((state_q == FETCH) || ((state_q == WAIT) && imem_rvalid));
  assign imem_addr  = fetch_pc_q;
  assign issue      = imem_req && imem_ready;
  assign fetch_pc_d = fetch_pc_q + 32'd4;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= FETCH;
      fetch_pc_q <= RESET_PC;
      req_pc_q   <= RESET_PC;
    end else if (redirect_valid) begin
      fetch_pc_q <= {redirect_pc[31:2], 2'b00};
      // A response landing in the redirect cycle retires the outstanding request.
      if (state_q != FETCH) state_q <= imem_rvalid ? FETCH : DROP;
    end else begin
      unique case (state_q)
        FETCH: begin
          if (issue) begin
            req_pc_q   <= fetch_pc_q;
            fetch_pc_q <= fetch_pc_d;
            state_q    <= WAIT;
          end
        end
        WAIT: begin
          if (imem_rvalid) begin
            if (issue) begin
              req_pc_q   <= fetch_pc_q;
              fetch_pc_q <= fetch_pc_d;
            end else begin
              state_q <= FETCH;
            end
          end
        end
        DROP: begin
          if (imem_rvalid) state_q <= FETCH;
        end
        default: state_q <= FETCH;
      endcase
    end
  end

`ifdef IFU_ILLEGAL_CHECK_EN
  logic head_illegal;
  assign q_wdata = {is_illegal(imem_rdata), req_pc_q, imem_rdata};
  assign {head_illegal, instr_pc, instr} = q_rdata;
  assign instr_illegal = instr_valid && head_illegal;
`else
  assign q_wdata = {req_pc_q, imem_rdata};
  assign {instr_pc, instr} = q_rdata;
  assign instr_illegal = 1'b0;
`endif

  ifu_queue #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (PW)
  ) u_queue (
    .clk   (clk),
    .rst   (rst),
    .push  (push),
    .pop   (pop),
    .flush (redirect_valid),
    .wdata (q_wdata),
    .rdata (q_rdata),
    .count (count)
  );

  assign instr_valid = (count != '0);

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DEPTH = 2;

  logic        clk = 1'b0;
  logic        rst;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ready;
  logic        imem_rvalid;
  logic [31:0] imem_rdata;
  logic        instr_valid;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic        instr_illegal;
  logic        instr_ready;
  logic        redirect_valid;
  logic [31:0] redirect_pc;

  always #5 clk = ~clk;

  instr_fetch_unit #(
    .RESET_PC   (32'h0000_0000),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .imem_req       (imem_req),
    .imem_addr      (imem_addr),
    .imem_ready     (imem_ready),
    .imem_rvalid    (imem_rvalid),
    .imem_rdata     (imem_rdata),
    .instr_valid    (instr_valid),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .instr_illegal  (instr_illegal),
    .instr_ready    (instr_ready),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc)
  );

  typedef struct {
    logic [31:0] addr;
    int          due;
    bit          stale;
    logic [31:0] data;
  } pend_t;

  typedef struct {
    logic [31:0] pc;
    logic [31:0] w;
  } exp_t;

  typedef struct {
    logic [31:0] rdata;
    bit          ill;
  } vec_t;

  pend_t       pend[$];
  exp_t        sb[$];
  int          total = 0;
  int          bad = 0;
  int          cycle = 0;
  int          lat = 1;
  int          pops = 0;
  int          issues = 0;
  bit          mem_ready = 1'b1;
  bit          ovr_en = 1'b0;
  logic [31:0] ovr_data = 32'h0;
  logic [31:0] exp_fetch_pc = 32'h0;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (ovr_en) return ovr_data;
    return {a[29:0], 2'b11} ^ 32'hA5C3_0000;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Returns at negedge+4 with ok=1 once imem_req is seen.
  task automatic wait_req(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (imem_req) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  task automatic wait_valid(output bit ok);
    ok = 1'b0;
    for (int k = 0; k < 12; k++) begin
      #3;
      if (instr_valid) begin
        ok = 1'b1;
        break;
      end
      tick();
    end
  endtask

  // imem model + scoreboard: drive response at negedge, observe at negedge+3.
  initial begin
    pend_t p;
    exp_t  e;
    imem_rvalid = 1'b0;
    imem_rdata  = 32'h0;
    imem_ready  = 1'b1;
    forever begin
      @(negedge clk);
      if (pend.size() != 0 && pend[0].due <= cycle + 1) begin
        imem_rvalid = 1'b1;
        imem_rdata  = pend[0].data;
      end else begin
        imem_rvalid = 1'b0;
        imem_rdata  = 32'h0;
      end
      imem_ready = mem_ready;
      #3;
      cycle++;
      if (rst) begin
        pend.delete();
        sb.delete();
        exp_fetch_pc = 32'h0;
      end else begin
        check("valid_vs_model", 32'(instr_valid), 32'(sb.size() != 0));
        if (redirect_valid) begin
          check("req_in_redirect", 32'(imem_req), 32'd0);
          if (imem_rvalid) p = pend.pop_front();
          foreach (pend[i]) pend[i].stale = 1'b1;
          sb.delete();
          exp_fetch_pc = {redirect_pc[31:2], 2'b00};
        end else begin
          if (instr_valid && instr_ready) begin
            pops++;
            if (sb.size() != 0) begin
              e = sb.pop_front();
              check("pop_pc", instr_pc, e.pc);
              check("pop_instr", instr, e.w);
            end
          end
          if (imem_rvalid) begin
            p = pend.pop_front();
            if (!p.stale) begin
              e.pc = p.addr;
              e.w  = p.data;
              sb.push_back(e);
            end
          end
          if (imem_req && imem_ready) begin
            issues++;
            check("fetch_addr", imem_addr, exp_fetch_pc);
            check("one_outstanding", 32'(pend.size()), 32'd0);
            p.addr  = exp_fetch_pc;
            p.due   = cycle + lat;
            p.stale = 1'b0;
            p.data  = mem_word(imem_addr);
            pend.push_back(p);
            exp_fetch_pc = exp_fetch_pc + 32'd4;
          end
        end
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        vecs[10];
    bit          ok;
    bit          found;
    bit          exp_ill;
    int          p0, i0;
    logic [31:0] hold_pc, hold_w;

    vecs[0] = '{32'h0000_0033, 1'b0};
    vecs[1] = '{32'h0000_0073, 1'b1};
    vecs[2] = '{32'h0000_0003, 1'b0};
    vecs[3] = '{32'h0000_0023, 1'b0};
    vecs[4] = '{32'h0000_0063, 1'b0};
    vecs[5] = '{32'h0000_0013, 1'b0};
    vecs[6] = '{32'h0000_0037, 1'b1};
    vecs[7] = '{32'h0000_0032, 1'b1};
    vecs[8] = '{32'h0000_006F, 1'b1};
    vecs[9] = '{32'hFFFF_FFB3, 1'b0};

    rst = 1'b1;
    instr_ready = 1'b1;
    redirect_valid = 1'b0;
    redirect_pc = 32'h0;

    // reset state
    repeat (2) tick();
    #3;
    check("rst_req", 32'(imem_req), 32'd0);
    check("rst_valid", 32'(instr_valid), 32'd0);
    check("rst_illegal", 32'(instr_illegal), 32'd0);

    tick();
    rst = 1'b0;
    #3;
    check("first_req", 32'(imem_req), 32'd1);
    check("first_addr", imem_addr, 32'h0);

    // streaming at one instruction per cycle
    repeat (10) tick();
    p0 = pops;
    repeat (10) tick();
    check("throughput", 32'(pops - p0), 32'd10);

    // decode stall: queue fills to depth, head holds
    instr_ready = 1'b0;
    repeat (2) tick();
    #3;
    hold_pc = instr_pc;
    hold_w  = instr;
    i0 = issues;
    repeat (8) tick();
    #3;
    check("stall_req", 32'(imem_req), 32'd0);
    check("stall_valid", 32'(instr_valid), 32'd1);
    check("stall_pc", instr_pc, hold_pc);
    check("stall_instr", instr, hold_w);
    check("stall_issues", 32'(issues - i0), 32'd0);
    check("stall_depth", 32'(sb.size()), 32'(DEPTH));
    tick();
    instr_ready = 1'b1;
    repeat (8) tick();

    // redirect while a latency-3 request is outstanding
    lat = 3;
    repeat (10) tick();
    found = 1'b0;
    for (int k = 0; k < 20; k++) begin
      tick();
      if (pend.size() != 0 && !imem_rvalid) begin
        found = 1'b1;
        break;
      end
    end
    check("redir_setup", 32'(found), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0102;
    tick();
    redirect_valid = 1'b0;
    #3;
    check("redir_valid0", 32'(instr_valid), 32'd0);
    tick();
    wait_req(ok);
    check("redir_req_seen", 32'(ok), 32'd1);
    check("redir_addr", imem_addr, 32'h0000_0100);
    check("redir_empty", 32'(instr_valid), 32'd0);
    repeat (12) tick();

    // PC wrap at the top of the address space
    lat = 1;
    redirect_valid = 1'b1;
    redirect_pc = 32'hFFFF_FFFC;
    tick();
    redirect_valid = 1'b0;
    wait_req(ok);
    check("wrap_req_seen", 32'(ok), 32'd1);
    check("wrap_addr0", imem_addr, 32'hFFFF_FFFC);
    tick();
    #3;
    check("wrap_req1", 32'(imem_req), 32'd1);
    check("wrap_addr1", imem_addr, 32'h0000_0000);
    tick();
    #3;
    check("wrap_valid", 32'(instr_valid), 32'd1);
    check("wrap_pc0", instr_pc, 32'hFFFF_FFFC);
    tick();
    #3;
    check("wrap_pc1", instr_pc, 32'h0000_0000);

    // redirect coinciding with a response and a pop
    repeat (5) tick();
    check("coinc_setup", 32'(imem_rvalid && instr_valid), 32'd1);
    redirect_valid = 1'b1;
    redirect_pc = 32'h0000_0200;
    tick();
    redirect_valid = 1'b0;
    #3;
    check("coinc_valid0", 32'(instr_valid), 32'd0);
    check("coinc_req", 32'(imem_req), 32'd1);
    check("coinc_addr", imem_addr, 32'h0000_0200);
    repeat (8) tick();

    // reset in the middle of outstanding traffic
    lat = 3;
    repeat (7) tick();
    rst = 1'b1;
    repeat (2) tick();
    rst = 1'b0;
    #3;
    check("mid_rst_req", 32'(imem_req), 32'd1);
    check("mid_rst_addr", imem_addr, 32'h0000_0000);
    repeat (12) tick();

    // opcode screen table
    lat = 1;
    instr_ready = 1'b0;
    foreach (vecs[i]) begin
      tick();
      ovr_en = 1'b1;
      ovr_data = vecs[i].rdata;
      redirect_valid = 1'b1;
      redirect_pc = 32'h0000_0300;
      tick();
      redirect_valid = 1'b0;
      wait_valid(ok);
`ifdef IFU_ILLEGAL_CHECK_EN
      exp_ill = vecs[i].ill;
`else
      exp_ill = 1'b0;
`endif
      check("vec_valid", 32'(ok), 32'd1);
      check("vec_instr", instr, vecs[i].rdata);
      check("vec_pc", instr_pc, 32'h0000_0300);
      check("vec_illegal", 32'(instr_illegal), 32'(exp_ill));
    end
    ovr_en = 1'b0;
    tick();
    instr_ready = 1'b1;
    repeat (6) tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
